// File: rtl/clkdiv_bringup_sequencer_pkg.sv
// rtl/clkdiv_bringup_sequencer_pkg.sv - shared types and constants for the CLKDIV bring-up sequencer
// Contents: seq_state_t (sequencer states), LOCK_SYNC_STAGES (pll_lock synchroniser depth).
package clkdiv_seq_pkg;

  localparam int LOCK_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_STABLE    = 3'd1,
    S_SETTLE    = 3'd2,
    S_READY     = 3'd3,
    S_CALIB     = 3'd4,
    S_RECOVER   = 3'd5
  } seq_state_t;

endpackage

// File: rtl/clkdiv_bringup_sequencer_if.sv
// rtl/clkdiv_bringup_sequencer_if.sv - lock, calibration handshake and CLKDIV control bundle
// Signals: pll_lock, calib_req (towards the sequencer); clkdiv_resetn, calib,
//          domain_reset, ready, calib_ack (from the sequencer).
// Modports: master = sequencer side, slave = board / CLKDIV wrapper side.
interface clkdiv_seq_if;
  logic pll_lock;
  logic calib_req;
  logic clkdiv_resetn;
  logic calib;
  logic domain_reset;
  logic ready;
  logic calib_ack;

  modport master (
    input  pll_lock, calib_req,
    output clkdiv_resetn, calib, domain_reset, ready, calib_ack
  );

  modport slave (
    output pll_lock, calib_req,
    input  clkdiv_resetn, calib, domain_reset, ready, calib_ack
  );
endinterface

// File: rtl/clkdiv_bringup_sequencer_sync2.sv
// rtl/clkdiv_bringup_sequencer_sync2.sv - two-flop synchroniser for an asynchronous level
// Ports: clk, reset (sync, active-high), d (async input), q (synchronised output).
module sync2
  import clkdiv_seq_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [LOCK_SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (reset) begin
      ff <= '0;
    end else begin
      ff <= {ff[LOCK_SYNC_STAGES-2:0], d};
    end
  end

  assign q = ff[LOCK_SYNC_STAGES-1];

endmodule

// File: rtl/clkdiv_bringup_sequencer.sv
// rtl/clkdiv_bringup_sequencer.sv - PLL-lock gated bring-up and CALIB stepping for the CLKDIV /2 path
// Ports: clk (fast PLL clock = CLKDIV HCLKIN), reset (sync, active-high),
//        bus (clkdiv_seq_if.master: pll_lock, calib_req in; clkdiv_resetn,
//        calib, domain_reset, ready, calib_ack out).
module clkdiv_bringup_sequencer
  import clkdiv_seq_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int SETTLE_CYCLES      = 16,
  parameter int CALIB_CYCLES       = 2
) (
  input  logic         clk,
  input  logic         reset,
  clkdiv_seq_if.master bus
);

  localparam int MAX_A = (LOCK_STABLE_CYCLES > SETTLE_CYCLES) ? LOCK_STABLE_CYCLES : SETTLE_CYCLES;
  localparam int MAX_P = (MAX_A > CALIB_CYCLES) ? MAX_A : CALIB_CYCLES;
  localparam int CW    = $clog2(MAX_P) + 1;

  seq_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          ack_nxt;
  logic          at_term;
  logic          lock_sync;

  sync2 u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.pll_lock),
    .q     (lock_sync)
  );

  // Terminal count of whichever timed state is active.
  always_comb begin
    at_term = 1'b0;
    case (state)
      S_STABLE:            at_term = (cnt == CW'(LOCK_STABLE_CYCLES - 1));
      S_SETTLE, S_RECOVER: at_term = (cnt == CW'(SETTLE_CYCLES - 1));
      S_CALIB:             at_term = (cnt == CW'(CALIB_CYCLES - 1));
      default:             at_term = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    ack_nxt   = 1'b0;
    if (!lock_sync) begin
      // Lock loss wins over everything, including a same-cycle calib_req.
      state_nxt = S_WAIT_LOCK;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_WAIT_LOCK: begin
          state_nxt = S_STABLE;
          cnt_nxt   = '0;
        end
        S_STABLE: if (at_term) begin
          state_nxt = S_SETTLE;
          cnt_nxt   = '0;
        end
        S_SETTLE: if (at_term) begin
          state_nxt = S_READY;
          cnt_nxt   = '0;
        end
        S_READY: begin
          cnt_nxt = cnt;
          if (bus.calib_req) begin
            state_nxt = S_CALIB;
            cnt_nxt   = '0;
          end
        end
        S_CALIB: if (at_term) begin
          state_nxt = S_RECOVER;
          cnt_nxt   = '0;
        end
        S_RECOVER: if (at_term) begin
          state_nxt = S_READY;
          cnt_nxt   = '0;
          ack_nxt   = 1'b1;
        end
        default: begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_WAIT_LOCK;
      cnt               <= '0;
      bus.clkdiv_resetn <= 1'b0;
      bus.calib         <= 1'b0;
      bus.domain_reset  <= 1'b1;
      bus.ready         <= 1'b0;
      bus.calib_ack     <= 1'b0;
    end else begin
      state             <= state_nxt;
      cnt               <= cnt_nxt;
      bus.clkdiv_resetn <= (state_nxt != S_WAIT_LOCK) && (state_nxt != S_STABLE);
      bus.calib         <= (state_nxt == S_CALIB);
      bus.domain_reset  <= (state_nxt != S_READY);
      bus.ready         <= (state_nxt == S_READY);
      bus.calib_ack     <= ack_nxt;
    end
  end

endmodule

// File: tb/tb_clkdiv_bringup_sequencer.sv
// tb/tb_clkdiv_bringup_sequencer.sv - directed self-checking bench for clkdiv_bringup_sequencer
module tb_clkdiv_bringup_sequencer;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  clkdiv_seq_if bus ();

  clkdiv_bringup_sequencer #(
    .LOCK_STABLE_CYCLES (8),
    .SETTLE_CYCLES      (4),
    .CALIB_CYCLES       (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic rn, input logic cal,
                            input logic dr, input logic rdy, input logic ack);
    chk({tag, ".clkdiv_resetn"}, bus.clkdiv_resetn, rn);
    chk({tag, ".calib"},         bus.calib,         cal);
    chk({tag, ".domain_reset"},  bus.domain_reset,  dr);
    chk({tag, ".ready"},         bus.ready,         rdy);
    chk({tag, ".calib_ack"},     bus.calib_ack,     ack);
  endtask

  // Raises pll_lock so the next edge is edge 0, then checks edges 0..last_edge.
  task automatic bringup(input string tag, input int last_edge);
    bus.pll_lock = 1'b1;
    for (int e = 0; e <= last_edge; e++) begin
      tick();
      expect_all($sformatf("%s.e%0d", tag, e), (e >= 10), 1'b0, (e < 14), (e >= 14), 1'b0);
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.pll_lock  = 1'b0;
    bus.calib_req = 1'b0;
    repeat (3) tick();
    expect_all("reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    tick();
    expect_all("wait_lock", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Clean bring-up: resetn at edge 10, ready at edge 14.
    bringup("bringup", 14);

    // Single calibration: calib_req driven at edge t, sampled at t+1.
    bus.calib_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) bus.calib_req = 1'b0;
      expect_all($sformatf("calib.t%0d", k), 1'b1, (k <= 2), (k < 7), (k >= 7), (k == 7));
    end

    // Lock loss while in CALIB overrides the move to RECOVER.
    bus.calib_req = 1'b1;
    bus.pll_lock  = 1'b0;
    tick();
    bus.calib_req = 1'b0;
    expect_all("lossc.t1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    expect_all("lossc.t2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    expect_all("lossc.t3", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 4; k <= 9; k++) begin
      tick();
      expect_all($sformatf("lossc.t%0d", k), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end

    // Reset sampled at edge 12 (mid-SETTLE), then a full bring-up again.
    bringup("pre_rst", 11);
    reset = 1'b1;
    tick();
    expect_all("rst_settle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    bringup("post_rst", 14);

    // One-cycle lock glitch sampled at edge 6; edge 7 becomes the new edge 0.
    bus.pll_lock = 1'b0;
    repeat (4) tick();
    expect_all("glitch_idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    bringup("glitch_pre", 5);
    bus.pll_lock = 1'b0;
    tick();
    expect_all("glitch.e6", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    bringup("glitch_post", 14);

    // calib_req held high from before READY: back-to-back calibrations every 7 cycles.
    bus.pll_lock = 1'b0;
    repeat (4) tick();
    bus.calib_req = 1'b1;
    bringup("held_pre", 14);
    for (int k = 1; k <= 15; k++) begin
      int m;
      tick();
      m = k % 7;
      expect_all($sformatf("held.k%0d", k), 1'b1, (m == 1 || m == 2), (m != 0), (m == 0), (m == 0));
    end
    bus.calib_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
